// File: rtl/winograd_pkg.sv
// Shared types for the Winograd convolution core and its result streamer.
package winograd_pkg;
  localparam int WG_OUT_ROWS = 8;
  localparam int WG_OUT_COLS = 10;
  localparam int WG_DATA_W   = 32;

  typedef logic [WG_DATA_W-1:0] wg_word_t;
  typedef wg_word_t [WG_OUT_ROWS-1:0][WG_OUT_COLS-1:0] wg_frame_t;

  typedef enum logic {ST_IDLE, ST_STREAM} wg_state_t;
endpackage

// File: rtl/winograd_result_bank.sv
// One frame of result storage: whole-array write in one edge, combinational row/col read.
// Zero-latency read; no flow control of its own.
module winograd_result_bank
  import winograd_pkg::*;
#(
  parameter int ROWS   = WG_OUT_ROWS,
  parameter int COLS   = WG_OUT_COLS,
  parameter int DATA_W = WG_DATA_W,
  parameter int ROW_W  = $clog2(ROWS),
  parameter int COL_W  = $clog2(COLS)
) (
  input  logic                                   clk,
  input  logic                                   i_we,
  input  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  i_wr_frame,
  input  logic [ROW_W-1:0]                       i_rd_row,
  input  logic [COL_W-1:0]                       i_rd_col,
  output logic [DATA_W-1:0]                      o_rd_data
);
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (i_we) r_mem <= i_wr_frame;
  end

  assign o_rd_data = r_mem[i_rd_row][i_rd_col];
endmodule

// File: rtl/winograd_result_streamer.sv
// Double-buffered word-serial readout of the 8x10 result array; m_valid 1 cycle after conv_done,
// beats held under backpressure. WINOGRAD_STREAM_CHECKSUM_EN appends a sum beat per frame.
module winograd_result_streamer
  import winograd_pkg::*;
#(
  parameter int ROWS   = WG_OUT_ROWS,
  parameter int COLS   = WG_OUT_COLS,
  parameter int DATA_W = WG_DATA_W
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   conv_done,
  input  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  result_in,
  output logic [DATA_W-1:0]                      m_data,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic                                   m_last,
  output logic [$clog2(ROWS+1)-1:0]              m_row,
  output logic [$clog2(COLS)-1:0]                m_col,
  output logic                                   busy,
  output logic                                   overflow,
  output logic [15:0]                            frame_cnt
);
  localparam int ROW_W  = $clog2(ROWS+1);
  localparam int COL_W  = $clog2(COLS);
  localparam int RIDX_W = $clog2(ROWS);

  wg_state_t           r_state;
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_occ;
  logic [ROW_W-1:0]    r_row;
  logic [COL_W-1:0]    r_col;
  logic                r_overflow;
  logic [15:0]         r_frame_cnt;

  logic                w_hs;
  logic                w_beat_last;
  logic                w_final;
  logic                w_cap;
  logic                w_drop;
  logic [1:0]          w_occ_nxt;
  logic [DATA_W-1:0]   w_rd_data [2];
  logic [DATA_W-1:0]   w_word;

  assign m_valid   = (r_state == ST_STREAM);
  assign w_hs      = m_valid && m_ready;
  assign w_final   = w_hs && w_beat_last;
  // A full buffer still accepts a frame when its reader frees the bank on the same edge.
  assign w_cap     = conv_done && ((r_occ != 2'd2) || w_final);
  assign w_drop    = conv_done && !w_cap;
  assign w_occ_nxt = r_occ + {1'b0, w_cap} - {1'b0, w_final};
  assign w_word    = r_rd_ptr ? w_rd_data[1] : w_rd_data[0];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    winograd_result_bank #(
      .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W)
    ) u_bank (
      .clk        (clk),
      .i_we       (w_cap && (r_wr_ptr == 1'(b))),
      .i_wr_frame (result_in),
      .i_rd_row   (r_row[RIDX_W-1:0]),
      .i_rd_col   (r_col),
      .o_rd_data  (w_rd_data[b])
    );
  end

`ifdef WINOGRAD_STREAM_CHECKSUM_EN
  logic              r_sum;
  logic [DATA_W-1:0] r_acc;
  logic              w_sum_beat;

  // Element (ROWS-1, COLS-1) naturally advances to row ROWS, which is the checksum beat.
  assign w_sum_beat  = (r_row == ROW_W'(ROWS));
  assign w_beat_last = w_sum_beat;
  assign m_data      = !m_valid ? '0 : (w_sum_beat ? r_acc : w_word);

  always_ff @(posedge clk) begin
    if (rst || w_final) r_acc <= '0;
    else if (w_hs)      r_acc <= r_acc + w_word;
    r_sum <= 1'b0;
  end
`else
  assign w_beat_last = (r_row == ROW_W'(ROWS-1)) && (r_col == COL_W'(COLS-1));
  assign m_data      = m_valid ? w_word : '0;
`endif

  assign m_last    = m_valid && w_beat_last;
  assign m_row     = r_row;
  assign m_col     = r_col;
  assign busy      = (r_occ != 2'd0);
  assign overflow  = r_overflow;
  assign frame_cnt = r_frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_occ       <= 2'd0;
      r_row       <= '0;
      r_col       <= '0;
      r_overflow  <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_occ <= w_occ_nxt;
      if (w_cap)  r_wr_ptr   <= ~r_wr_ptr;
      if (w_drop) r_overflow <= 1'b1;
      if (w_final) begin
        r_rd_ptr    <= ~r_rd_ptr;
        r_frame_cnt <= r_frame_cnt + 16'd1;
        r_row       <= '0;
        r_col       <= '0;
      end else if (w_hs) begin
        if (r_col == COL_W'(COLS-1)) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      case (r_state)
        ST_IDLE:   if (w_occ_nxt != 2'd0) r_state <= ST_STREAM;
        ST_STREAM: if (w_occ_nxt == 2'd0) r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_winograd_result_streamer.sv
// Directed bench for winograd_result_streamer with a frame-queue reference model.
module tb_winograd_result_streamer;
  localparam int ROWS = 8;
  localparam int COLS = 10;
  localparam int DW   = 32;
`ifdef WINOGRAD_STREAM_CHECKSUM_EN
  localparam int L = ROWS*COLS + 1;
`else
  localparam int L = ROWS*COLS;
`endif

  logic clk = 1'b0;
  logic rst, conv_done, m_ready;
  logic [ROWS-1:0][COLS-1:0][DW-1:0] result_in;
  logic [DW-1:0] m_data;
  logic m_valid, m_last, busy, overflow;
  logic [3:0] m_row, m_col;
  logic [15:0] frame_cnt;

  winograd_result_streamer dut (
    .clk(clk), .rst(rst), .conv_done(conv_done), .result_in(result_in),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .m_row(m_row), .m_col(m_col), .busy(busy), .overflow(overflow),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: pending words of accepted frames, in stream order.
  logic [DW-1:0] wq[$];
  int  nq = 0, bi = 0, e_fcnt = 0;
  bit  e_ovf = 0, mon_en = 0;

  logic [DW-1:0] rxq[$];
  int  hs_cnt = 0, cyc = 0, first_hs = -1, last_hs = -1;
  logic [DW-1:0] last_data;

  always @(negedge clk) begin
    bit exp_valid, e_hs, fin;
    int n0;
    logic [DW-1:0] s;
    cyc++;
    if (mon_en) begin
      exp_valid = (nq != 0);
      chk("m_valid", m_valid, exp_valid);
      chk("busy", busy, exp_valid);
      chk("overflow", overflow, e_ovf);
      chk("frame_cnt", frame_cnt, e_fcnt[15:0]);
      if (exp_valid) begin
        chk("m_data", m_data, wq[0]);
        chk("m_row", m_row, bi / COLS);
        chk("m_col", m_col, bi % COLS);
        chk("m_last", m_last, bi == L-1);
      end else begin
        chk("m_data_idle", m_data, 0);
        chk("m_last_idle", m_last, 0);
      end
      if (m_valid && m_ready) begin
        rxq.push_back(m_data);
        hs_cnt++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (m_last) last_data = m_data;
      end
      e_hs = exp_valid && m_ready;
      if (rst) begin
        wq.delete(); nq = 0; bi = 0; e_fcnt = 0; e_ovf = 0;
      end else begin
        n0  = nq;
        fin = e_hs && (bi == L-1);
        if (e_hs) begin
          void'(wq.pop_front());
          bi++;
          if (fin) begin bi = 0; nq--; e_fcnt = (e_fcnt + 1) & 16'hffff; end
        end
        if (conv_done) begin
          if (n0 < 2 || fin) begin
            s = '0;
            for (int r = 0; r < ROWS; r++)
              for (int c = 0; c < COLS; c++) begin
                wq.push_back(result_in[r][c]);
                s = s + result_in[r][c];
              end
`ifdef WINOGRAD_STREAM_CHECKSUM_EN
            wq.push_back(s);
`endif
            nq++;
          end else begin
            e_ovf = 1;
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clr_rx;
    rxq.delete(); hs_cnt = 0; first_hs = -1; last_hs = -1; last_data = 'x;
  endtask

  task automatic set_ramp;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) result_in[r][c] = DW'(r*10 + c);
  endtask

  task automatic set_const(input logic [DW-1:0] v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) result_in[r][c] = v;
  endtask

  task automatic pulse;
    conv_done = 1'b1; tick; conv_done = 1'b0;
  endtask

  task automatic wait_hs(input string nm, input int n);
    int k = 0;
    while (hs_cnt < n && k < 2000) begin tick; k++; end
    chk(nm, hs_cnt >= n, 1);
  endtask

  task automatic drain(input string nm, input bit toggle);
    int k = 0;
    while ((busy || m_valid) && k < 2000) begin
      if (toggle) m_ready = ~m_ready;
      tick; k++;
    end
    m_ready = 1'b1;
    chk(nm, busy || m_valid, 0);
  endtask

  // Counts words of rxq[base +: 80] differing from the ramp (ramp=1) or from v.
  function automatic int run_errs(input int base, input bit ramp, input logic [DW-1:0] v);
    int e = 0;
    for (int i = 0; i < ROWS*COLS; i++) begin
      if (base + i >= rxq.size()) e++;
      else if (rxq[base+i] !== (ramp ? DW'(i) : v)) e++;
    end
    return e;
  endfunction

  initial begin
    rst = 1'b1; conv_done = 1'b0; m_ready = 1'b0; result_in = '0;
    tick;
    mon_en = 1;
    tick;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_row_col", {m_row, m_col}, 0);
    rst = 1'b0;
    tick;

    // Single frame, no backpressure.
    clr_rx; set_ramp; m_ready = 1'b1;
    pulse;
    chk("t1_latency", m_valid, 1);
    drain("t1_timeout", 0);
    chk("t1_count", rxq.size(), L);
    chk("t1_order", run_errs(0, 1, '0), 0);
`ifdef WINOGRAD_STREAM_CHECKSUM_EN
    chk("t1_checksum_last", last_data, 3160);
`else
    chk("t1_last_data", last_data, 79);
`endif
    chk("t1_frame_cnt", frame_cnt, 1);

    // Backpressure, ready toggling every cycle.
    clr_rx; set_ramp; m_ready = 1'b1;
    pulse;
    drain("t2_timeout", 1);
    chk("t2_count", rxq.size(), L);
    chk("t2_order", run_errs(0, 1, '0), 0);
    chk("t2_frame_cnt", frame_cnt, 2);

    // Back-to-back frames with no bubble.
    clr_rx; set_const(5); m_ready = 1'b1;
    pulse;
    wait_hs("t3_wait30", 30);
    set_const(7);
    pulse;
    drain("t3_timeout", 0);
    chk("t3_count", rxq.size(), 2*L);
    chk("t3_frameA", run_errs(0, 0, 5), 0);
    chk("t3_frameB", run_errs(L, 0, 7), 0);
    chk("t3_no_bubble", last_hs - first_hs + 1, 2*L);
    chk("t3_frame_cnt", frame_cnt, 4);
    chk("t3_overflow", overflow, 0);

    // Reset at beat 40.
    clr_rx; set_ramp; m_ready = 1'b1;
    pulse;
    wait_hs("t6_wait40", 40);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t6_valid_after_rst", m_valid, 0);
    chk("t6_busy_after_rst", busy, 0);
    chk("t6_fcnt_after_rst", frame_cnt, 0);
    tick;
    clr_rx;
    pulse;
    drain("t6_timeout", 0);
    chk("t6_count", rxq.size(), L);
    chk("t6_order", run_errs(0, 1, '0), 0);

    // Capture on the releasing handshake of a full buffer.
    clr_rx; m_ready = 1'b0;
    set_const(11); pulse;
    set_const(22); pulse;
    m_ready = 1'b1;
    wait_hs("t5_wait_final", L-1);
    set_const(33);
    pulse;
    chk("t5_overflow", overflow, 0);
    drain("t5_timeout", 0);
    chk("t5_count", rxq.size(), 3*L);
    chk("t5_f1", run_errs(0, 0, 11), 0);
    chk("t5_f2", run_errs(L, 0, 22), 0);
    chk("t5_f3", run_errs(2*L, 0, 33), 0);

    // Overflow with both banks full.
    clr_rx; m_ready = 1'b0;
    set_const(1); pulse;
    set_const(2); pulse;
    set_const(3); pulse;
    tick;
    chk("t4_overflow", overflow, 1);
    m_ready = 1'b1;
    drain("t4_timeout", 0);
    chk("t4_count", rxq.size(), 2*L);
    chk("t4_f1", run_errs(0, 0, 1), 0);
    chk("t4_f2", run_errs(L, 0, 2), 0);
    chk("t4_overflow_sticky", overflow, 1);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
